// File: rtl/array_ctrl_pkg.sv
// Shared types and constants for the array back end: frame layout, FSM states,
// and the timing-parameter helpers.
package array_ctrl_pkg;

  localparam int ARRAY_COL_ADDR_WIDTH   = 6;
  localparam int ARRAY_ROW_ADDR_WIDTH   = 16;
  localparam int ARRAY_DATA_WIDTH       = 64;
  localparam int ARRAY_FRAME_DATA_WIDTH = 3 + ARRAY_COL_ADDR_WIDTH + ARRAY_ROW_ADDR_WIDTH + ARRAY_DATA_WIDTH;

  localparam int CADDR_LSB = 0;
  localparam int RADDR_LSB = 6;
  localparam int DATA_LSB  = 22;
  localparam int RW_BIT    = 86;
  localparam int SOF_BIT   = 87;
  localparam int EOF_BIT   = 88;

  typedef enum logic [2:0] {IDLE, ACT, ACCESS, CLOSE, PRE, RF_ACT, RF_PRE} state_e;

  // Field order matches the bit positions above (eof is the MSB).
  typedef struct packed {
    logic                            eof;
    logic                            sof;
    logic                            rw;
    logic [ARRAY_DATA_WIDTH-1:0]     data;
    logic [ARRAY_ROW_ADDR_WIDTH-1:0] raddr;
    logic [ARRAY_COL_ADDR_WIDTH-1:0] caddr;
  } frame_t;

  // A programmed timing value of 0 behaves as 1.
  function automatic logic [7:0] t_eff(input logic [7:0] t);
    return (t == 8'd0) ? 8'd1 : t;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/array_rdata_sync.sv
// Brings the asynchronous array read strobe into clk: 2-flop synchroniser,
// rising-edge detect, and capture of the (stable) read data.
module array_rdata_sync
  import array_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdata_vld,
  input  logic [ARRAY_DATA_WIDTH-1:0] rdata,
  output logic                        sync_vld,
  output logic [ARRAY_DATA_WIDTH-1:0] sync_data
);

  localparam int STAGES = 2;

  // [1:0] is the synchroniser, [2] is the previous synchronised value.
  logic [STAGES:0] vld_pipe;
  logic            rise;

  assign rise = vld_pipe[STAGES-1] & ~vld_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      sync_vld  <= 1'b0;
      sync_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], rdata_vld};
      sync_vld <= rise;
      if (rise) sync_data <= rdata;
    end
  end

endmodule

// File: rtl/array_ctrl_core.sv
// Array back end: turns frame beats into activate / column burst / precharge
// sequences, enforces array timing, and interleaves periodic refresh.
module array_ctrl_core
  import array_ctrl_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              mc_en,
  input  logic                              axi2array_frame_valid,
  input  logic [ARRAY_FRAME_DATA_WIDTH-1:0] axi2array_frame_data,
  output logic                              axi2array_frame_ready,
  input  logic                              array_rf_period_sel,
  input  logic [24:0]                       array_rf_period_0,
  input  logic [24:0]                       array_rf_period_1,
  input  logic [7:0]                        array_tRCD_WR,
  input  logic [7:0]                        array_tRAS,
  input  logic [7:0]                        array_tWR,
  input  logic [7:0]                        array_tRP,
  input  logic [7:0]                        array_tRCD_RD,
  input  logic [7:0]                        array_tRTP,
  output logic                              array_cs_n,
  output logic [ARRAY_ROW_ADDR_WIDTH-1:0]   array_raddr,
  output logic                              array_caddr_vld_wr,
  output logic [ARRAY_COL_ADDR_WIDTH-1:0]   array_caddr_wr,
  output logic                              array_caddr_vld_rd,
  output logic [ARRAY_COL_ADDR_WIDTH-1:0]   array_caddr_rd,
  output logic                              array_wdata_vld,
  output logic [ARRAY_DATA_WIDTH-1:0]       array_wdata,
  input  logic                              array_rdata_vld,
  input  logic [ARRAY_DATA_WIDTH-1:0]       array_rdata,
  output logic                              sync_array_rdata_vld,
  output logic [ARRAY_DATA_WIDTH-1:0]       sync_array_rdata
);

  state_e                          state, state_nxt;
  frame_t                          beat;
  logic [7:0]                      cnt, ras_cnt, gap_cnt;
  logic [ARRAY_ROW_ADDR_WIDTH-1:0] open_row, rf_row;
  logic                            open_rw, row_hit, hs;
  logic                            rf_pending, rf_done, rf_hit, sel_q;
  logic [24:0]                     rf_cnt, rf_period;
  logic                            sof_unused;

  assign beat       = frame_t'(axi2array_frame_data);
  assign sof_unused = beat.sof;
  assign row_hit    = (beat.raddr == open_row) && (beat.rw == open_rw);
  assign hs         = axi2array_frame_valid && axi2array_frame_ready;
  assign array_cs_n = !(state inside {ACT, ACCESS, CLOSE, RF_ACT});

  assign rf_period = array_rf_period_sel ? array_rf_period_1 : array_rf_period_0;
  assign rf_hit    = mc_en && (rf_period != 25'd0) && (sel_q == array_rf_period_sel)
                     && (rf_cnt >= rf_period - 25'd1);

  always_comb begin
    state_nxt             = state;
    axi2array_frame_ready = 1'b0;
    rf_done               = 1'b0;
    case (state)
      IDLE: begin
        if (mc_en && rf_pending)                 state_nxt = RF_ACT;
        else if (mc_en && axi2array_frame_valid) state_nxt = ACT;
      end
      ACT:
        if (cnt >= t_eff(open_rw ? array_tRCD_WR : array_tRCD_RD) - 8'd1) state_nxt = ACCESS;
      ACCESS: begin
        axi2array_frame_ready = mc_en && axi2array_frame_valid && row_hit;
        // A refresh only breaks in when the stream pauses; an eof beat is accepted before closing.
        if (!mc_en || (axi2array_frame_valid && (!row_hit || beat.eof))
            || (!axi2array_frame_valid && rf_pending))
          state_nxt = CLOSE;
      end
      CLOSE:
        if (gap_cnt >= t_eff(open_rw ? array_tWR : array_tRTP) - 8'd1
            && ras_cnt >= t_eff(array_tRAS) - 8'd1)
          state_nxt = PRE;
      PRE:
        if (cnt >= t_eff(array_tRP) - 8'd1) state_nxt = IDLE;
      RF_ACT:
        if (cnt >= t_eff(array_tRAS) - 8'd1) state_nxt = RF_PRE;
      RF_PRE:
        if (cnt >= t_eff(array_tRP) - 8'd1) begin
          state_nxt = IDLE;
          rf_done   = 1'b1;
        end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= '0;
      ras_cnt            <= '0;
      gap_cnt            <= '0;
      open_row           <= '0;
      open_rw            <= 1'b0;
      rf_row             <= '0;
      rf_cnt             <= '0;
      rf_pending         <= 1'b0;
      sel_q              <= 1'b0;
      array_raddr        <= '0;
      array_caddr_vld_wr <= 1'b0;
      array_caddr_wr     <= '0;
      array_caddr_vld_rd <= 1'b0;
      array_caddr_rd     <= '0;
      array_wdata_vld    <= 1'b0;
      array_wdata        <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= (state_nxt != state) ? 8'd0 : sat_inc(cnt);
      ras_cnt <= (state_nxt == ACT && state != ACT) ? 8'd0 : sat_inc(ras_cnt);
      // gap_cnt is the age of the last strobe; a row with no strobes owes no write/read recovery.
      if (hs)                                     gap_cnt <= 8'd0;
      else if (state == ACT && state_nxt == ACCESS) gap_cnt <= 8'hFF;
      else                                        gap_cnt <= sat_inc(gap_cnt);

      if (state == IDLE && state_nxt == ACT) begin
        open_row    <= beat.raddr;
        open_rw     <= beat.rw;
        array_raddr <= beat.raddr;
      end else if (state == IDLE && state_nxt == RF_ACT) begin
        array_raddr <= rf_row;
      end

      array_caddr_vld_wr <= hs && open_rw;
      array_wdata_vld    <= hs && open_rw;
      array_caddr_vld_rd <= hs && !open_rw;
      if (hs && open_rw) begin
        array_caddr_wr <= beat.caddr;
        array_wdata    <= beat.data;
      end
      if (hs && !open_rw) array_caddr_rd <= beat.caddr;

      sel_q <= array_rf_period_sel;
      if (!mc_en || rf_period == 25'd0 || sel_q != array_rf_period_sel || rf_hit) rf_cnt <= '0;
      else                                                                        rf_cnt <= rf_cnt + 25'd1;
      if (rf_hit)       rf_pending <= 1'b1;
      else if (rf_done) rf_pending <= 1'b0;
      if (rf_done) rf_row <= rf_row + 1'b1;
    end
  end

  array_rdata_sync u_rdata_sync (
    .clk       (clk),
    .rst       (rst),
    .rdata_vld (array_rdata_vld),
    .rdata     (array_rdata),
    .sync_vld  (sync_array_rdata_vld),
    .sync_data (sync_array_rdata)
  );

endmodule

// File: tb/tb_array_ctrl_core.sv
// Directed bench for array_ctrl_core: write/read bursts, refresh, refresh
// deferral, enable gating, read-data sync and reset behaviour.
module tb_array_ctrl_core;
  import array_ctrl_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, mc_en = 1'b0, valid = 1'b0, ready;
  frame_t      fr = '0;
  logic        rf_sel = 1'b0;
  logic [24:0] rf_p0 = '0, rf_p1 = '0;
  logic [7:0]  t_rcd_wr = 8'd7, t_ras = 8'd16, t_wr = 8'd6, t_rp = 8'd6, t_rcd_rd = 8'd7, t_rtp = 8'd3;
  logic        cs_n, vld_wr, vld_rd, wdata_vld, rdata_vld = 1'b0, sync_vld;
  logic [15:0] raddr;
  logic [5:0]  caddr_wr, caddr_rd;
  logic [63:0] wdata, rdata = '0, sync_rdata;

  array_ctrl_core dut (
    .clk(clk), .rst(rst), .mc_en(mc_en),
    .axi2array_frame_valid(valid), .axi2array_frame_data(fr), .axi2array_frame_ready(ready),
    .array_rf_period_sel(rf_sel), .array_rf_period_0(rf_p0), .array_rf_period_1(rf_p1),
    .array_tRCD_WR(t_rcd_wr), .array_tRAS(t_ras), .array_tWR(t_wr), .array_tRP(t_rp),
    .array_tRCD_RD(t_rcd_rd), .array_tRTP(t_rtp),
    .array_cs_n(cs_n), .array_raddr(raddr),
    .array_caddr_vld_wr(vld_wr), .array_caddr_wr(caddr_wr),
    .array_caddr_vld_rd(vld_rd), .array_caddr_rd(caddr_rd),
    .array_wdata_vld(wdata_vld), .array_wdata(wdata),
    .array_rdata_vld(rdata_vld), .array_rdata(rdata),
    .sync_array_rdata_vld(sync_vld), .sync_array_rdata(sync_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // ---- monitor: cs_n episodes, strobes, sync pulses (sampled on negedge)
  typedef struct {int cyc; logic [15:0] row; logic [5:0] col; logic [63:0] data; logic wr;} st_t;
  st_t         st_q[$];
  int          vr_q[$], sy_cyc[$];
  logic [63:0] sy_dat[$];
  int          cyc = 0, ep_n = 0, rdy_hits = 0, cs_lo_hits = 0;
  int          ep_fall[16], ep_rise[16], ep_first[16], ep_last[16];
  logic [15:0] ep_row[16];
  logic        ep_open = 1'b0, cs_prev = 1'b1, vld_prev = 1'b0, clr = 1'b0;

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    cs_prev  <= cs_n;
    vld_prev <= rdata_vld;
    if (clr) begin
      ep_n <= 0; ep_open <= 1'b0; rdy_hits <= 0; cs_lo_hits <= 0;
      st_q.delete(); vr_q.delete(); sy_cyc.delete(); sy_dat.delete();
    end else if (!rst) begin
      if (ready) rdy_hits <= rdy_hits + 1;
      if (!cs_n) cs_lo_hits <= cs_lo_hits + 1;
      if (cs_prev && !cs_n && ep_n < 16) begin
        ep_fall[ep_n] <= cyc; ep_row[ep_n] <= raddr;
        ep_first[ep_n] <= -1; ep_last[ep_n] <= -1; ep_open <= 1'b1;
      end
      if ((vld_wr || vld_rd) && ep_open) begin
        if (ep_first[ep_n] < 0) ep_first[ep_n] <= cyc;
        ep_last[ep_n] <= cyc;
      end
      if (vld_wr || vld_rd) st_q.push_back('{cyc, raddr, vld_wr ? caddr_wr : caddr_rd, wdata, vld_wr});
      if (!cs_prev && cs_n && ep_open) begin
        ep_rise[ep_n] <= cyc; ep_n <= ep_n + 1; ep_open <= 1'b0;
      end
      if (rdata_vld && !vld_prev) vr_q.push_back(cyc);
      if (sync_vld) begin sy_cyc.push_back(cyc); sy_dat.push_back(sync_rdata); end
    end
  end

  // ---- stimulus helpers (all called at posedge+1)
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    clr = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0;
    tick(3);
    rst = 1'b0;
    clear();
  endtask

  task automatic send_beat(input logic [15:0] row, input logic [5:0] col, input logic [63:0] d,
                           input logic rw, input logic sof, input logic eof);
    logic r;
    int   k;
    fr.eof = eof; fr.sof = sof; fr.rw = rw; fr.data = d; fr.raddr = row; fr.caddr = col;
    valid = 1'b1;
    r = 1'b0; k = 0;
    while (!r && k < 400) begin
      @(negedge clk); r = ready;
      @(posedge clk); #1; k++;
    end
    if (!r) chk("hs_timeout", 1, 0);
  endtask

  task automatic wait_ep(input int n, input int budget);
    int k;
    k = 0;
    while (ep_n < n && k < budget) begin @(posedge clk); k++; end
    #1;
    chk("wait_ep", 64'(ep_n >= n), 1);
  endtask

  // Row closes when both the strobe recovery time and tRAS have elapsed.
  function automatic int exp_rise(input int e, input int t_close);
    int a, b;
    a = ep_last[e] + t_close;
    b = ep_fall[e] + int'(t_ras);
    return (a > b) ? a : b;
  endfunction

  logic [63:0] exp_d[10];
  int          idx;

  initial begin
    // reset state
    tick(2);
    @(negedge clk);
    chk("rst_cs_n", cs_n, 1); chk("rst_ready", ready, 0); chk("rst_raddr", raddr, 0);
    chk("rst_vld_wr", vld_wr, 0); chk("rst_vld_rd", vld_rd, 0); chk("rst_wdata", wdata, 0);
    chk("rst_sync", {sync_vld, sync_rdata}, 0);
    @(posedge clk); #1;
    mc_en = 1'b1;
    do_reset();

    // write frame: 64 beats on row 0 then 4 on row 1
    for (int n = 0; n < 68; n++)
      send_beat(16'(n >> 6), 6'(n), 64'd1, 1'b1, n == 0, n == 67);
    valid = 1'b0;
    tick(40);
    chk("wr_count", st_q.size(), 68);
    for (int n = 0; n < 68 && n < st_q.size(); n++) begin
      chk("wr_row", st_q[n].row, 64'(n >> 6));
      chk("wr_col", st_q[n].col, 64'(n % 64));
      chk("wr_data", st_q[n].data, 1);
      chk("wr_dir", st_q[n].wr, 1);
    end
    chk("wr_eps", ep_n, 2);
    for (int e = 0; e < 2; e++) begin
      chk("wr_rcd", ep_first[e] - ep_fall[e], 8);
      chk("wr_close", ep_rise[e], exp_rise(e, 6));
      chk("wr_row_open", ep_row[e], e);
    end
    chk("wr_close_row0", ep_rise[0] - ep_last[0], 6);
    // PRE holds tRP cycles, then IDLE spends one cycle deciding to reopen
    chk("wr_pre_gap", ep_fall[1] - ep_rise[0], 7);

    // read frame: rows 0,1 full, row 2 with 4 beats
    clear();
    for (int n = 0; n < 132; n++)
      send_beat(16'(n >> 6), 6'(n), 64'd0, 1'b0, n == 0, n == 131);
    valid = 1'b0;
    tick(40);
    chk("rd_count", st_q.size(), 132);
    for (int n = 0; n < 132 && n < st_q.size(); n++) begin
      chk("rd_row", st_q[n].row, 64'(n >> 6));
      chk("rd_col", st_q[n].col, 64'(n % 64));
      chk("rd_dir", st_q[n].wr, 0);
    end
    chk("rd_eps", ep_n, 3);
    for (int e = 0; e < 3; e++) begin
      chk("rd_rcd", ep_first[e] - ep_fall[e], 8);
      chk("rd_close", ep_rise[e], exp_rise(e, 3));
    end
    chk("rd_close_row0", ep_rise[0] - ep_last[0], 3);
    chk("rd_close_row2", ep_rise[2] - ep_fall[2], 16);

    // controller disabled with a beat waiting
    clear();
    mc_en = 1'b0; rf_p0 = 25'd50;
    fr = '0; fr.raddr = 16'd9; fr.rw = 1'b1; valid = 1'b1;
    tick(60);
    chk("mcen_ready", rdy_hits, 0);
    chk("mcen_cs", cs_lo_hits, 0);
    chk("mcen_eps", ep_n, 0);
    valid = 1'b0; rf_p0 = '0; mc_en = 1'b1;
    tick(2);

    // idle refresh, period_1 selected, then switch to period_0
    rf_p0 = 25'd100; rf_p1 = 25'd120; rf_sel = 1'b1;
    do_reset();
    wait_ep(3, 600);
    rf_sel = 1'b0;
    for (int e = 0; e < 3; e++) begin
      chk("rf_low", ep_rise[e] - ep_fall[e], 16);
      chk("rf_row", ep_row[e], e);
    end
    chk("rf_period1_a", ep_fall[1] - ep_fall[0], 120);
    chk("rf_period1_b", ep_fall[2] - ep_fall[1], 120);
    wait_ep(6, 500);
    chk("rf_period0_a", ep_fall[4] - ep_fall[3], 100);
    chk("rf_period0_b", ep_fall[5] - ep_fall[4], 100);
    chk("rf_row5", ep_row[5], 5);
    rf_p0 = '0; rf_p1 = '0;

    // refresh requested mid-burst waits for eof, then runs before the next frame
    rf_p0 = 25'd30;
    do_reset();
    for (int n = 0; n < 40; n++) send_beat(16'd5, 6'(n), 64'(n), 1'b1, n == 0, n == 39);
    for (int n = 0; n < 4; n++)  send_beat(16'd6, 6'(n), 64'(n), 1'b1, n == 0, n == 3);
    valid = 1'b0;
    tick(60);
    rf_p0 = '0;
    chk("rfb_eps", 64'(ep_n >= 3), 1);
    chk("rfb_row0", ep_row[0], 5);
    chk("rfb_burst", ep_last[0] - ep_first[0], 39);
    chk("rfb_rf_row", ep_row[1], 0);
    chk("rfb_rf_low", ep_rise[1] - ep_fall[1], 16);
    chk("rfb_rf_gap", ep_fall[1] - ep_rise[0], 7);
    chk("rfb_row2", ep_row[2], 6);
    chk("rfb_count", st_q.size(), 44);

    // tRCD_WR of 0 behaves as 1
    do_reset();
    t_rcd_wr = 8'd0;
    send_beat(16'd7, 6'd3, 64'hA5, 1'b1, 1'b1, 1'b1);
    valid = 1'b0;
    tick(30);
    chk("rcd0_lat", ep_first[0] - ep_fall[0], 2);
    chk("rcd0_col", (st_q.size() > 0) ? st_q[0].col : 6'h3F, 3);
    t_rcd_wr = 8'd7;

    // read-data sync
    clear();
    for (int i = 0; i < 10; i++) begin
      exp_d[i] = {$urandom, $urandom};
      rdata = exp_d[i]; rdata_vld = 1'b1;
      tick(6);
      rdata_vld = 1'b0;
      tick(6);
    end
    chk("sync_rises", vr_q.size(), 10);
    chk("sync_pulses", sy_cyc.size(), 10);
    for (int i = 0; i < 10 && i < sy_cyc.size() && i < vr_q.size(); i++) begin
      chk("sync_lat", sy_cyc[i] - vr_q[i], 3);
      chk("sync_data", sy_dat[i], exp_d[i]);
    end

    // reset in the middle of a burst
    clear();
    fr = '0; fr.raddr = 16'd3; fr.rw = 1'b1; fr.data = 64'hDEAD; fr.caddr = 6'd9; valid = 1'b1;
    tick(14);
    @(negedge clk);
    chk("mid_cs_lo", cs_n, 0);
    chk("mid_wvld", wdata_vld, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_cs", cs_n, 1); chk("mid_rst_wvld", wdata_vld, 0); chk("mid_rst_wdata", wdata, 0);
    chk("mid_rst_raddr", raddr, 0); chk("mid_rst_caddr", caddr_wr, 0); chk("mid_rst_ready", ready, 0);
    chk("mid_rst_sync", sync_rdata, 0);
    valid = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);

    idx = n_pass;
    $display("%0d/%0d checks passed", idx, n_chk);
    $finish;
  end

endmodule
